// File: rtl/alu_resp_tx.sv
// alu_resp_tx: accepts one ALU result, frames it as an 8-byte response packet, and shifts it out on a UART TX line.
// Optional macro ALU_RESP_TX_PARITY_EN adds an even-parity bit to every byte frame (8E1 instead of 8N1).
`timescale 1ns/1ps

module alu_resp_tx #(
  parameter int CLK_FREQ_HZ = 27_750_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  input  logic [7:0]  res_opcode_i,
  input  logic [31:0] res_data_i,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
      $error("alu_resp_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef ALU_RESP_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [31:0]   data_q, data_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic          accept_s;
  logic          bit_end_s;
  logic [7:0]    cur_byte_s;

  // Response packet layout: opcode, reserved, 16-bit length (8, includes header), then data little-endian.
  function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [7:0] op,
                                          input logic [31:0] d);
    case (idx)
      3'd0:    pkt_byte = op;
      3'd1:    pkt_byte = 8'h00;
      3'd2:    pkt_byte = 8'h08;
      3'd3:    pkt_byte = 8'h00;
      3'd4:    pkt_byte = d[7:0];
      3'd5:    pkt_byte = d[15:8];
      3'd6:    pkt_byte = d[23:16];
      3'd7:    pkt_byte = d[31:24];
      default: pkt_byte = 8'h00;
    endcase
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    even_parity = ^b;
  endfunction

  assign accept_s   = res_valid_i & ready_q;
  assign bit_end_s  = (baud_q == BAUD_LAST);
  assign cur_byte_s = pkt_byte(byte_q, opcode_q, data_q);

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 3'd0;
      opcode_q <= 8'h00;
      data_q   <= 32'h0000_0000;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      opcode_q <= opcode_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d  = S_START;
          opcode_d = res_opcode_i;
          data_d   = res_data_i;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) state_d = S_DATA;
        else           state_d = S_START;
      end
      S_DATA: begin
        if (bit_end_s && (bit_q == 3'd7)) begin
`ifdef ALU_RESP_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef ALU_RESP_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) state_d = S_STOP;
        else           state_d = S_PARITY;
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          if (byte_q == 3'd7) state_d = S_IDLE;
          else                state_d = S_START;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE) begin
      baud_d = '0;
    end else if (bit_end_s) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + CW'(1);
    end

    if (state_q == S_DATA) begin
      if (bit_end_s) bit_d = bit_q + 3'd1;
      else           bit_d = bit_q;
    end else begin
      bit_d = 3'd0;
    end

    // byte_idx wraps 7 -> 0 on the final stop bit, leaving it cleared for the next packet.
    if (state_q == S_IDLE) begin
      byte_d = 3'd0;
    end else if ((state_q == S_STOP) && bit_end_s) begin
      byte_d = byte_q + 3'd1;
    end else begin
      byte_d = byte_q;
    end
  end

  // Output logic: the line level follows the current state one cycle later.
  always_comb begin
    case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte_s[bit_q];
`ifdef ALU_RESP_TX_PARITY_EN
      S_PARITY: tx_d = even_parity(cur_byte_s);
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    if (state_d == S_IDLE) begin
      ready_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      ready_d = 1'b0;
      busy_d  = 1'b1;
    end
  end

  assign tx_o        = tx_q;
  assign res_ready_o = ready_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_alu_resp_tx.sv
// Bench for alu_resp_tx: a cycle-level packet model checked every cycle, plus a line decoder
// compared against hand-written byte strings. Honours ALU_RESP_TX_PARITY_EN like the design.
`timescale 1ns/1ps

module tb_alu_resp_tx;

  // Non-integer clock/baud ratio so truncation is exercised: 2_800_000/115_200 = 24.3 -> 24.
  localparam int CLK_HZ = 2_800_000;
  localparam int BAUD   = 115_200;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef ALU_RESP_TX_PARITY_EN
  localparam int FRAME  = 11;
`else
  localparam int FRAME  = 10;
`endif
  localparam int PKT    = 8 * FRAME * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid_i = 1'b0;
  logic [7:0]  res_opcode_i = 8'h00;
  logic [31:0] res_data_i = 32'h0;
  logic        res_ready_o;
  logic        tx_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_resp_tx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst(rst), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_opcode_i(res_opcode_i), .res_data_i(res_data_i), .tx_o(tx_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a packet is 8 bytes, each a FRAME-bit frame of CPB cycles, starting
  // the cycle after the accept edge; idle is one cycle after the packet's last cycle.
  bit         m_active = 1'b0;
  bit         m_ready  = 1'b0;
  int         m_t      = 0;
  int         m_acc    = 0;
  int         cyc      = 0;
  logic [7:0] m_pkt [8];

  function automatic logic model_tx();
    int b, byt, pos;
    if (!m_active || m_t < 1) return 1'b1;
    b   = (m_t - 1) / CPB;
    byt = b / FRAME;
    pos = b % FRAME;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_pkt[byt][pos-1];
    if (FRAME == 11 && pos == 9) return ^m_pkt[byt];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_active = 1'b0;
        m_ready  = 1'b0;
        m_t      = 0;
      end else if (m_active) begin
        m_t++;
        if (m_t == PKT) begin
          m_active = 1'b0;
          m_ready  = 1'b1;
        end
      end else if (m_ready && res_valid_i) begin
        m_pkt[0] = res_opcode_i;
        m_pkt[1] = 8'h00;
        m_pkt[2] = 8'h08;
        m_pkt[3] = 8'h00;
        m_pkt[4] = res_data_i[7:0];
        m_pkt[5] = res_data_i[15:8];
        m_pkt[6] = res_data_i[23:16];
        m_pkt[7] = res_data_i[31:24];
        m_active = 1'b1;
        m_ready  = 1'b0;
        m_t      = 0;
        m_acc++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Every-cycle compare, mid-cycle; reset forces the idle values asynchronously.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("tx_o", tx_o, 1'b1);
        check("res_ready_o", res_ready_o, 1'b0);
        check("busy_o", busy_o, 1'b0);
      end else begin
        check("tx_o", tx_o, model_tx());
        check("res_ready_o", res_ready_o, m_ready);
        check("busy_o", busy_o, m_active);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  int t_acc = 0;

  task automatic send(input logic [7:0] op, input logic [31:0] d, input int bound);
    int c0;
    bit got;
    c0  = m_acc;
    got = 1'b0;
    @(posedge clk); #2;
    res_valid_i  = 1'b1;
    res_opcode_i = op;
    res_data_i   = d;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (m_acc != c0) begin
        got = 1'b1;
        break;
      end
    end
    t_acc = cyc;
    #1;
    res_valid_i  = 1'b0;
    res_opcode_i = 8'($urandom);
    res_data_i   = $urandom;
    check("accept_seen", got, 1'b1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (res_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_seen", ok, 1'b1);
  endtask

  task automatic rx_byte(output logic [7:0] b, output logic p);
    bit seen;
    seen = 1'b0;
    b = 8'h00;
    p = 1'b0;
    for (int i = 0; i < 4 * PKT; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("rx_start_seen", seen, 1'b1);
    repeat (CPB / 2) @(negedge clk);
    check("rx_start_bit", tx_o, 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB) @(negedge clk);
      b[k] = tx_o;
    end
    if (FRAME == 11) begin
      repeat (CPB) @(negedge clk);
      p = tx_o;
    end
    repeat (CPB) @(negedge clk);
    check("rx_stop_bit", tx_o, 1'b1);
  endtask

  task automatic rx_packet(input string tag, input logic [63:0] exp, output logic [7:0] pars);
    logic [7:0] b;
    logic       p;
    logic [7:0] e;
    pars = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rx_byte(b, p);
      e = exp[63-8*i -: 8];
      pars[i] = p;
      check({tag, "_byte"}, b, e);
      if (FRAME == 11) check({tag, "_parity"}, p, ^e);
    end
  endtask

  logic [7:0] pars;
  int lat;

  initial begin
    // Reset: held 5 cycles, ready rises on the first edge after release.
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_tx", tx_o, 1'b1);
    check("rst_ready", res_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    #1 rst = 1'b0;
    #1 check("ready_before_edge", res_ready_o, 1'b0);
    @(posedge clk); #1;
    check("ready_after_rst", res_ready_o, 1'b1);

    // Single packet with literal byte string and exact packet length.
    send(8'hEC, 32'h1234_5678, 10);
    rx_packet("single", 64'hEC00_0800_7856_3412, pars);
    wait_idle(PKT);
    lat = cyc - t_acc;
    check("packet_len", lat, PKT);

    // A result offered while busy is dropped.
    send(8'h5A, 32'hCAFE_F00D, 10);
    repeat (100) @(posedge clk);
    #2;
    res_valid_i  = 1'b1;
    res_opcode_i = 8'h99;
    res_data_i   = 32'hDEAD_BEEF;
    repeat (10) @(posedge clk);
    #2 res_valid_i = 1'b0;
    wait_idle(PKT);
    repeat (3 * CPB) @(posedge clk);
    #1 check("drop_no_second", busy_o, 1'b0);

    // Back-to-back: valid held, two results, 16 bytes with no gap inside each packet.
    fork
      begin
        send(8'h11, 32'h0403_0201, 10);
        #1;
        res_valid_i  = 1'b1;
        res_opcode_i = 8'h22;
        res_data_i   = 32'h0D0C_0B0A;
        lat = m_acc;
        for (int i = 0; i < PKT + 10; i++) begin
          @(posedge clk); #1;
          if (m_acc != lat) break;
        end
        #1 res_valid_i = 1'b0;
        check("b2b_second_accept", m_acc - lat, 1);
      end
      begin
        rx_packet("b2b_a", 64'h1100_0800_0102_0304, pars);
        rx_packet("b2b_b", 64'h2200_0800_0A0B_0C0D, pars);
      end
    join
    wait_idle(PKT);

    // Reset during a zero data bit of B5 forces the line high at once.
    send(8'h33, 32'hAA00_55FF, 10);
    repeat ((5 * FRAME + 4) * CPB + CPB / 2) @(posedge clk);
    #2 check("midrst_line_low", tx_o, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx_o, 1'b1);
    check("midrst_busy", busy_o, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    send(8'h01, 32'h0000_0000, 10);
    rx_packet("after_rst", 64'h0100_0800_0000_0000, pars);
    wait_idle(PKT);

    if (FRAME == 11) begin
      // Parity per byte for 01 00 08 00 07 00 00 00.
      send(8'h01, 32'h0000_0007, 10);
      rx_packet("parity", 64'h0100_0800_0700_0000, pars);
      check("parity_bits", pars, 8'b0001_0101);
      wait_idle(PKT);
      lat = cyc - t_acc;
      check("parity_packet_len", lat, PKT);
    end

    // Randomised packets with random gaps and stray valid pulses while busy.
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      send(8'($urandom), $urandom, 10);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, PKT - 40)) @(posedge clk);
        #2;
        res_valid_i = 1'b1;
        res_data_i  = $urandom;
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #2 res_valid_i = 1'b0;
      end
      wait_idle(PKT);
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
